// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, programmable
// bit period and registered status read-back on the CPU data bus.
module uart_tx_mmio #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [3:0]  wen,
  input  logic [21:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        idle
);

  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DIV_W   = 16;
  localparam int unsigned BIT_W   = 3;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state_q, state_d;
  logic [BYTE_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               overflow_q;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   period_q, period_d;
  logic [DIV_W-1:0]   tick_q, tick_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [BYTE_W-1:0]  shreg_q, shreg_d;
  logic               txd_d;
  logic [31:0]        rd_val;

  logic               full, empty, busy;
  logic               push_req, push_ok, pop;
  logic               ovf_set, ovf_clr, div_wr;
  logic               tick_end;
  logic               unused_bits;

  assign unused_bits = ^{addr[21:2], wen[3:2], wdata[31:16]};

  // Bus decode and FIFO handshake
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign busy     = (state_q != S_IDLE);
  assign pop      = (state_q == S_IDLE) & ~empty;
  assign push_req = sel & wen[0] & (addr[1:0] == 2'd0);
  assign push_ok  = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign ovf_clr  = sel & wen[0] & (addr[1:0] == 2'd1) & wdata[3];
  assign div_wr   = sel & (addr[1:0] == 2'd2);
  assign tick_end = (tick_q == period_q);

  // FIFO occupancy after this edge
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; entries only written on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= wdata[BYTE_W-1:0];
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      if (ovf_set)      overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
    end
  end

  // Bit-period divider register, byte-writable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= DEFAULT_DIV;
    end else if (div_wr) begin
      if (wen[0]) div_q[7:0]  <= wdata[7:0];
      if (wen[1]) div_q[15:8] <= wdata[15:8];
    end
  end

  // Register read mux on pre-edge state
  always_comb begin
    rd_val = '0;
    case (addr[1:0])
      2'd1:    rd_val = {28'd0, overflow_q, busy, empty, full};
      2'd2:    rd_val = {16'd0, div_q};
      default: rd_val = '0;
    endcase
  end

  // Registered read data, zero when not selected so responders can be OR-ed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= sel ? rd_val : '0;
  end

  // Framing FSM next state; txd is computed for the state being entered
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    period_d = period_q;
    txd_d    = txd;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!empty) begin
          shreg_d  = fifo_mem[rd_ptr_q];
          period_d = div_q;
          tick_d   = '0;
          state_d  = S_START;
          txd_d    = 1'b0;
        end
      end
      S_START: begin
        if (tick_end) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          txd_d   = shreg_q[0];
        end else begin
          tick_d = tick_q + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (tick_end) begin
          tick_d = '0;
          if (bit_q == BIT_W'(7)) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shreg_d = shreg_q >> 1;
            txd_d   = shreg_q[1];
          end
        end else begin
          tick_d = tick_q + DIV_W'(1);
        end
      end
      S_STOP: begin
        if (tick_end) begin
          tick_d  = '0;
          state_d = S_IDLE;
          txd_d   = 1'b1;
        end else begin
          tick_d = tick_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // Framing FSM registers plus registered txd/idle outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      period_q <= '0;
      txd      <= 1'b1;
      idle     <= 1'b1;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      period_q <= period_d;
      txd      <= txd_d;
      idle     <= (state_d == S_IDLE) && (count_d == '0);
    end
  end

endmodule
